tx_srrc_filter: RTL and testbench
=================================

Name: tx_srrc_filter

Overview:
- Transmit pulse-shaping FIR filter: a symmetric, linear-phase square-root raised-cosine filter.
- Takes one 18-bit signed 1s17 sample per clock, typically a 4-ASK symbol stream upsampled to 4 samples/symbol with zero stuffing.
- Produces one filtered 18-bit 1s17 sample per clock.
- Sits between the symbol mapper/upsampler and the DAC/channel model.
- Folded (pre-add) architecture with a fully pipelined datapath.

Parameters:
- NTAPS, 21, number of taps; must be odd; coefficients symmetric, H[k] = H[NTAPS-1-k].
- DW, 18, input/output sample width (signed).
- CW, 18, coefficient width (signed 1s17).
- FRAC, 17, fractional bits of input, coefficient and output.

Ports:
- clk  input  1  system clock; one sample per rising edge.
- reset  input  1  asynchronous, active-low reset (low = reset asserted).
- x_in  input  18  signed 1s17 input sample; sampled on every rising edge.
- y  output  18  signed 1s17 filtered output; registered.

Behaviour:
- Reset (reset low, asynchronous): clears the delay line, pre-add, product, accumulator and y registers to 0. Outputs are 0 until the pipeline refills after reset is released.
- Delay line: xd[0] <= x_in; xd[k] <= xd[k-1] for k = 1..NTAPS-1. Shifts every clock; there is no enable.
- Stage 1, pre-add: p[k] <= xd[k] + xd[NTAPS-1-k] for k = 0..(NTAPS-3)/2, each 19-bit signed. Centre term p[c] <= sign-extended xd[(NTAPS-1)/2].
- Stage 2, multiply: m[k] <= p[k] * H[k], 37-bit signed, full precision. (NTAPS+1)/2 multipliers, i.e. 11 for NTAPS = 21.
- Stage 3, sum: acc = sum of m[k], 41-bit signed, no intermediate truncation. y <= saturate(acc >>> FRAC) to the 18-bit signed range [-131072, 131071], using floor (truncation) rounding.
- Latency:
  - A sample on x_in at rising edge n contributes H[0] to y immediately after edge n+3.
  - It contributes H[j] to y immediately after edge n+3+j.
  - Fixed 3-register datapath latency plus the xd[0] input register.
- Throughput: one output per clock, no stalls, no handshake.
- Coefficients are pre-scaled so that sum |H[k]| <= 131071. A worst-case input (x = ±131071 · sign(H[k]) aligned on taps) therefore does not overflow. Saturation exists as a safety net and is required anyway.
- Reset mid-stream clears all state immediately. The first post-reset outputs reflect only post-reset samples (zero history).
- x = -131072 is a legal input. Pre-add of two -131072 values = -262144 fits in 19 bits.

Decomposition:
- Package tx_filt_pkg holds:
  - NTAPS, DW, CW, FRAC.
  - Sample/coefficient typedefs: sample_t is logic signed [17:0]; coef_t is logic signed [17:0].
  - The coefficient array H[0..(NTAPS-1)/2] as localparam coef_t values. These are the team's SRRC design: rolloff 0.25, 4 samples/symbol, 1s17. The bench model uses the same constants.
- Optional sub-module: sat_trunc, the generic arithmetic-shift and saturate-to-DW helper. All else lives in one module.

Test Plan:
- Reset: hold reset low with x_in = 50000 → y stays 0. After release, y stays 0 for the first 3 edges following the first sampled nonzero input.
- Impulse: x_in = 131071 for one sample, then 0 → y after edge n+3+j equals floor(131071·H[j]/2^17) for j = 0..20. The sequence is symmetric about j = 10, then y returns to 0.
- DC: constant x_in = 65536 (0.5) → steady-state y = floor(65536·ΣH/2^17), reached 24 clocks after the step.
- Worst case: x_in = +131071 where H aligned to that tap is positive and -131072 where negative → y peaks at floor(Σ|H|·131071/2^17) with no wrap. Repeat with signs inverted → most negative value, no wrap.
- 4-ASK: symbols {-98304, -32768, 32768, 98304} each followed by 3 zeros, random sequence → y matches the bit-exact reference model sample-for-sample at latency 3.
- Reset mid-stream: during the 4-ASK run, pulse reset low for 1 cycle between edges → y goes to 0 asynchronously. Output afterwards equals the model restarted with zero history.

Source files
------------

// File: rtl/tx_filt_pkg.sv
// rtl/tx_filt_pkg.sv - shared sizes, sample types and SRRC coefficients for tx_srrc_filter
package tx_filt_pkg;

  localparam int NTAPS = 21;
  localparam int DW    = 18;
  localparam int CW    = 18;
  localparam int FRAC  = 17;
  localparam int NHALF = (NTAPS + 1) / 2;
  localparam int PW    = DW + 1;
  localparam int MW    = PW + CW;
  localparam int AW    = MW + 4;

  typedef logic signed [DW-1:0] sample_t;
  typedef logic signed [CW-1:0] coef_t;

  // Rolloff 0.25, 4 samples/symbol, 1s17; H[NHALF-1] is the centre tap, sum |H| = 131000.
  localparam coef_t H [0:NHALF-1] = '{
    18'sd1300,  18'sd1050,  -18'sd150,  -18'sd2200, -18'sd3400, -18'sd2600,
    18'sd1000,  18'sd6800,  18'sd14500, 18'sd21000, 18'sd23000
  };

endpackage

// File: rtl/tx_srrc_filter_sat_trunc.sv
// rtl/tx_srrc_filter_sat_trunc.sv - arithmetic right shift then saturate to an OW-bit signed range
module sat_trunc #(
  parameter int IW    = 41,
  parameter int SHIFT = 17,
  parameter int OW    = 18
) (
  input  logic signed [IW-1:0] a,
  output logic signed [OW-1:0] q
);

  localparam logic signed [IW-1:0] MAXV = {{(IW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [IW-1:0] MINV = {{(IW-OW+1){1'b1}}, {(OW-1){1'b0}}};

  logic signed [IW-1:0] sh;

  always_comb begin
    sh = a >>> SHIFT;
    if (sh > MAXV)
      q = MAXV[OW-1:0];
    else if (sh < MINV)
      q = MINV[OW-1:0];
    else
      q = sh[OW-1:0];
  end

endmodule

// File: rtl/tx_srrc_filter.sv
// rtl/tx_srrc_filter.sv - folded symmetric SRRC transmit FIR, pre-add/multiply/sum pipeline
module tx_srrc_filter
  import tx_filt_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic signed [DW-1:0] x_in,
  output logic signed [DW-1:0] y
);

  sample_t              xd [NTAPS];
  logic signed [PW-1:0] p  [NHALF];
  logic signed [MW-1:0] m  [NHALF];
  logic signed [AW-1:0] acc;
  sample_t              y_sat;

  always_comb begin
    acc = '0;
    for (int k = 0; k < NHALF; k++)
      acc = acc + AW'(m[k]);
  end

  sat_trunc #(.IW(AW), .SHIFT(FRAC), .OW(DW)) u_sat (
    .a (acc),
    .q (y_sat)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NTAPS; k++) xd[k] <= '0;
      for (int k = 0; k < NHALF; k++) begin
        p[k] <= '0;
        m[k] <= '0;
      end
      y <= '0;
    end else begin
      xd[0] <= x_in;
      for (int k = 1; k < NTAPS; k++) xd[k] <= xd[k-1];
      // Mirrored taps share one multiplier; the centre tap has no partner.
      for (int k = 0; k < NHALF - 1; k++)
        p[k] <= PW'(xd[k]) + PW'(xd[NTAPS-1-k]);
      p[NHALF-1] <= PW'(xd[NHALF-1]);
      for (int k = 0; k < NHALF; k++)
        m[k] <= MW'(p[k]) * MW'(H[k]);
      y <= y_sat;
    end
  end

endmodule

// File: tb/tb_tx_srrc_filter.sv
// tb/tb_tx_srrc_filter.sv - directed scoreboard bench for tx_srrc_filter
module tb_tx_srrc_filter;
  import tx_filt_pkg::*;

  logic                 clk;
  logic                 reset;
  logic signed [DW-1:0] x_in;
  logic signed [DW-1:0] y;

  int     n_cmp = 0;
  int     n_err = 0;
  longint hist [NTAPS];
  longint exp_q [$];

  tx_srrc_filter dut (
    .clk   (clk),
    .reset (reset),
    .x_in  (x_in),
    .y     (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic longint coef(input int j);
    return (j < NHALF) ? longint'(H[j]) : longint'(H[NTAPS-1-j]);
  endfunction

  // Direct-form reference: unfolded tap sum, floor shift, clamp.
  function automatic longint model_out();
    longint s;
    s = 0;
    for (int j = 0; j < NTAPS; j++) s += hist[j] * coef(j);
    s = s >>> FRAC;
    if (s > 131071) s = 131071;
    if (s < -131072) s = -131072;
    return s;
  endfunction

  task automatic check(input string tag, input longint obs, input longint expv);
    n_cmp++;
    assert (obs === expv)
    else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic model_clear();
    for (int j = 0; j < NTAPS; j++) hist[j] = 0;
    exp_q.delete();
    repeat (3) exp_q.push_back(0);
  endtask

  task automatic step(input longint x, input string tag);
    longint e;
    x_in = DW'(x);
    @(posedge clk);
    for (int j = NTAPS - 1; j > 0; j--) hist[j] = hist[j-1];
    hist[0] = x;
    exp_q.push_back(model_out());
    #1;
    e = exp_q.pop_front();
    check(tag, longint'(y), e);
  endtask

  longint ref_v;
  longint dc_ref;
  longint sym;
  longint asks [4] = '{-98304, -32768, 32768, 98304};

  initial begin
    reset = 1'b0;
    x_in  = 18'sd50000;
    model_clear();
    repeat (4) begin
      @(posedge clk);
      #1 check("reset_hold", longint'(y), 0);
    end
    @(negedge clk);
    reset = 1'b1;

    // Impulse: y after step j carries floor(131071*H[j-3]/2^17).
    for (int j = 0; j < 28; j++) begin
      step((j == 0) ? 131071 : 0, "impulse_sb");
      ref_v = (j >= 3 && j <= 23) ? ((131071 * coef(j - 3)) >>> FRAC) : 0;
      check("impulse_tap", longint'(y), ref_v);
    end

    dc_ref = 0;
    for (int j = 0; j < NTAPS; j++) dc_ref += coef(j);
    dc_ref = (65536 * dc_ref) >>> FRAC;
    for (int i = 0; i < 30; i++) begin
      step(65536, "dc_sb");
      if (i >= 23) check("dc_steady", longint'(y), dc_ref);
    end
    repeat (24) step(0, "flush_sb");

    ref_v = 0;
    for (int j = 0; j < NTAPS; j++)
      ref_v += coef(j) * ((coef(j) >= 0) ? 131071 : -131072);
    ref_v = ref_v >>> FRAC;
    for (int i = 0; i < 24; i++) begin
      step((i < NTAPS) ? ((coef(i) >= 0) ? 131071 : -131072) : 0, "wc_pos_sb");
      if (i == 23) check("wc_pos_peak", longint'(y), ref_v);
    end
    repeat (24) step(0, "flush_sb");

    ref_v = 0;
    for (int j = 0; j < NTAPS; j++)
      ref_v += coef(j) * ((coef(j) >= 0) ? -131072 : 131071);
    ref_v = ref_v >>> FRAC;
    for (int i = 0; i < 24; i++) begin
      step((i < NTAPS) ? ((coef(i) >= 0) ? -131072 : 131071) : 0, "wc_neg_sb");
      if (i == 23) check("wc_neg_peak", longint'(y), ref_v);
    end
    repeat (24) step(0, "flush_sb");

    for (int s = 0; s < 120; s++) begin
      sym = asks[$urandom_range(0, 3)];
      step(sym, "ask_sb");
      repeat (3) step(0, "ask_sb");
      if (s == 60) begin
        #2 reset = 1'b0;
        #1 check("async_clear", longint'(y), 0);
        @(posedge clk);
        #1 check("reset_pulse_hold", longint'(y), 0);
        reset = 1'b1;
        model_clear();
      end
    end
    repeat (24) step(0, "tail_sb");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
